// File: rtl/shared_div_pkg.sv
// rtl/shared_div_pkg.sv - shared divider constants, tag type and saturation values
// Purpose: common definitions for the shared divider front end.
// Ports: none (package).
package shared_div_pkg;

    localparam int DIV_W     = 48;
    localparam int DIV_LAT   = 30;
    localparam int DIV_N     = 8;
    localparam int DIV_IDX_W = $clog2(DIV_N);

    localparam logic [DIV_W-1:0] DIV_QMAX = {1'b0, {(DIV_W-1){1'b1}}};
    localparam logic [DIV_W-1:0] DIV_QMIN = {1'b1, {(DIV_W-2){1'b0}}, 1'b1};

    // Travels alongside each operand pair for the divider's full latency.
    typedef struct packed {
        logic                 valid;
        logic [DIV_IDX_W-1:0] idx;
        logic                 dz;
        logic                 nsign;
    } div_tag_t;

endpackage

// File: rtl/shared_div_sched_rr_arbiter.sv
// rtl/shared_div_sched_rr_arbiter.sv - round-robin arbiter, one grant per clock
// Purpose: grants the lowest requesting index at or above the pointer, wrapping to 0.
// Ports: clk, rst (sync, active-high), req[N], grant[N] one-hot,
//        grant_idx (binary index of grant), grant_any (a grant was issued).
module rr_arbiter #(
    parameter  int N  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Scan N slots starting at the pointer; the first requester wins.
    always_comb begin
        int c;
        c         = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr_q) + k) % N;
            if (!rst && !grant_any && req[c]) begin
                grant[c]  = 1'b1;
                grant_idx = IW'(c);
                grant_any = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shared_div_sched.sv
// rtl/shared_div_sched.sv - serializes N client divide requests onto one pipelined divider
// Purpose: arbitrates client requests, issues one operand pair per clock, tracks owner
//          through the divider latency and returns each quotient to its issuer.
// Ports: clk, rst (sync, active-high); req_valid/req_n/req_d/req_ready per client;
//        div_n/div_d to divider (registered), div_q from divider;
//        rsp_valid one-hot pulse, rsp_q broadcast quotient, rsp_dz divide-by-zero flag.
// Build option: SHARED_DIV_ZERO_GUARD_EN enables divide-by-zero substitution and saturation.
module shared_div_sched
    import shared_div_pkg::*;
#(
    parameter int N   = DIV_N,
    parameter int W   = DIV_W,
    parameter int LAT = DIV_LAT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_n,
    input  logic [N*W-1:0] req_d,
    output logic [N-1:0]   req_ready,
    output logic [W-1:0]   div_n,
    output logic [W-1:0]   div_d,
    input  logic [W-1:0]   div_q,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_q,
    output logic           rsp_dz
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  grant;
    logic [IW-1:0] gidx;
    logic          gany;

    rr_arbiter #(.N(N)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .grant     (grant),
        .grant_idx (gidx),
        .grant_any (gany)
    );

    assign req_ready = grant;

    logic [W-1:0] sel_n;
    logic [W-1:0] sel_d;
    assign sel_n = req_n[gidx*W +: W];
    assign sel_d = req_d[gidx*W +: W];

    logic [W-1:0] div_n_q, div_n_d;
    logic [W-1:0] div_d_q, div_d_d;
    div_tag_t     tag_q [LAT+1];
    div_tag_t     tag_d;
    div_tag_t     tag_out;
    logic [N-1:0] rsp_valid_q, rsp_valid_d;
    logic [W-1:0] rsp_q_q, rsp_q_d;
    logic         rsp_dz_q, rsp_dz_d;

`ifdef SHARED_DIV_ZERO_GUARD_EN
    localparam logic [W-1:0] QMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] QMIN = {1'b1, {(W-2){1'b0}}, 1'b1};
`endif

    // Idle cycles feed 0/1 so the divider never sees a zero denominator.
    always_comb begin
        div_n_d = '0;
        div_d_d = W'(1);
        tag_d   = '0;
        if (gany) begin
            div_n_d     = sel_n;
            div_d_d     = sel_d;
            tag_d.valid = 1'b1;
            tag_d.idx   = DIV_IDX_W'(gidx);
            tag_d.nsign = sel_n[W-1];
`ifdef SHARED_DIV_ZERO_GUARD_EN
            if (sel_d == '0) begin
                div_d_d  = W'(1);
                tag_d.dz = 1'b1;
            end
`endif
        end
    end

    // The last tag stage lines up with the divider output for the same request.
    assign tag_out = tag_q[LAT];

    always_comb begin
        rsp_valid_d = '0;
        rsp_q_d     = div_q;
        rsp_dz_d    = 1'b0;
        if (tag_out.valid) begin
            rsp_valid_d[tag_out.idx] = 1'b1;
        end
`ifdef SHARED_DIV_ZERO_GUARD_EN
        if (tag_out.valid && tag_out.dz) begin
            rsp_dz_d = 1'b1;
            rsp_q_d  = tag_out.nsign ? QMIN : QMAX;
        end
`endif
    end

`ifndef SHARED_DIV_ZERO_GUARD_EN
    logic tag_unused;
    assign tag_unused = tag_out.dz ^ tag_out.nsign;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            div_n_q     <= '0;
            div_d_q     <= W'(1);
            rsp_valid_q <= '0;
            rsp_q_q     <= '0;
            rsp_dz_q    <= 1'b0;
            for (int k = 0; k <= LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            div_n_q     <= div_n_d;
            div_d_q     <= div_d_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q_q     <= rsp_q_d;
            rsp_dz_q    <= rsp_dz_d;
            tag_q[0]    <= tag_d;
            for (int k = 1; k <= LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign div_n     = div_n_q;
    assign div_d     = div_d_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_dz    = rsp_dz_q;

endmodule

// File: doc/shared_div_sched.md
Name: shared_div_sched

Overview:
- Client-side front end for the pipelined shared divider.
- Accepts divide requests from N voice/DSP instances and serializes them onto the single divider, issuing at most one request per clock.
- Tracks each request's owner through the divider's fixed pipeline latency and returns each quotient to the instance that issued it.
- Sits between the per-voice DSP modules and the shared divider instance.

Parameters:
- N, 8, number of client instances sharing the divider.
- W, 48, numerator/denominator/quotient width.
- LAT, 30, divider pipeline latency in clocks; must match the divider build.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  N  per-client request valid
- req_n  in  N*W  per-client numerator, client i at bits [i*W +: W], signed
- req_d  in  N*W  per-client denominator, same packing, signed
- req_ready  out  N  one-hot grant; handshake when req_valid[i] & req_ready[i]
- div_n  out  W  numerator to divider, registered
- div_d  out  W  denominator to divider, registered
- div_q  in  W  quotient from divider
- rsp_valid  out  N  one-hot, one-cycle quotient-valid pulse
- rsp_q  out  W  quotient, broadcast to all clients, qualified by rsp_valid
- rsp_dz  out  1  divide-by-zero flag for the current response (optional feature only; tied 0 otherwise)

Behaviour:
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_q = 0, rsp_dz = 0
  - div_n = 0, div_d = 1
  - RR pointer = 0
  - every tag-pipeline valid bit = 0
- Arbitration (round robin):
  - req_ready is combinational from req_valid and the pointer; it never depends on rsp.
  - Grant goes to the lowest index i ≥ ptr with req_valid[i]; if none, wrap to index 0 and continue.
  - On a grant, ptr <= (i+1) mod N. With no request, ptr holds.
  - req_ready is all-zero while rst is high.
- Client rule: hold req_valid, req_n and req_d stable until granted. Dropping req_valid before a grant is legal: the request is simply withdrawn.
- Issue:
  - On the handshake cycle T, register div_n/div_d from the granted client.
  - With no grant, drive div_n = 0, div_d = 1 (benign filler).
- Tag pipeline:
  - Shift register of depth LAT+1, each entry holding {valid, client index (clog2 N bits), dz}.
  - Entry written at T; the divider output for that entry appears at T+1+LAT.
- Response:
  - Registered at edge T+LAT+2: rsp_valid = onehot(tag.idx) & tag.valid, and rsp_q = div_q.
  - Latency is exactly LAT+2 clocks, handshake cycle to rsp_valid.
- Throughput: one issue per clock. A client may have several requests in flight; its responses return in issue order.
- Arithmetic: div_q passes through unchanged (signed truncating division, remainder sign follows numerator). No rescaling here.
- Boundaries:
  - All N requesting → each client granted once every N cycles.
  - N=1 → the pointer stays 0.
  - Reset mid-operation clears all tag valids, so in-flight quotients are discarded and no rsp_valid occurs until a new request completes.
  - Request and response for the same client in the same cycle are independent.

Optional Feature:
- Macro: SHARED_DIV_ZERO_GUARD_EN.
- Defined:
  - A request with d == 0 issues div_d = 1 and carries dz = 1 in its tag.
  - At response, rsp_dz = 1 and rsp_q is saturated: +max (0x7FFF_FFFF_FFFF) for n ≥ 0, -max (0x8000_0000_0001) for n < 0. The numerator sign is carried in the tag.
- Undefined:
  - d passes through unchanged and rsp_dz is tied 0.
  - The quotient for d == 0 is whatever the divider produces; clients must avoid d == 0.

Decomposition:
- Package shared_div_pkg holds:
  - constants DIV_W = 48 and DIV_LAT = 30
  - typedef div_tag_t {valid, idx, dz, nsign}
  - saturation constants DIV_QMAX / DIV_QMIN
- One sub-module, rr_arbiter (parameter N; ports req, grant, ptr update). It is reusable by other shared DSP resources.

Test Plan:
- Single request: client 3, n=100, d=7 at cycle 10 → rsp_valid = 0b0000_1000 at cycle 42, rsp_q = 14. No other pulses.
- All 8 clients request continuously, client i: n=i*10, d=5 → grants in order 0,1,…,7,0,… with one grant per cycle. Each client gets q=2i; the first response arrives 32 cycles after the first grant.
- Pointer fairness: ptr=5 with clients 2 and 6 requesting → 6 granted first, then 2.
- Negative operands: n=-7, d=2 → rsp_q = -3 (truncation toward zero).
- Reset mid-flight: issue 5 requests, assert rst for 1 cycle at cycle 15 → zero rsp_valid pulses for the next 40 cycles.
- With SHARED_DIV_ZERO_GUARD_EN: n=-9, d=0 → rsp_dz=1, rsp_q=0x8000_0000_0001. Without the macro, rsp_dz stays 0.
